m31_subtractor_pipe: RTL and testbench
======================================

// Module: m31_subtractor_pipe
// PURPOSE
//  Pipelined modular subtractor over M31 (p = 2^31-1): out = (a - b) mod p, canonical.
//  Inverse companion of the M31 adder for the Monolith datapath (round-constant removal, inverse layers).
//  Two register stages with valid/ready flow control; carries an opaque tag for result matching.
// PARAMETERS
//  TAG_WIDTH   4   width of the opaque tag passed alongside each operation
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          block can accept a beat this cycle
//  in_a       in   31         minuend, range [0, p]; value p is congruent to 0
//  in_b       in   31         subtrahend, range [0, p]
//  in_tag     in   TAG_WIDTH  opaque tag, returned unchanged
//  out_valid  out  1          result beat valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  31         (a - b) mod p, always in [0, p-1]
//  out_tag    out  TAG_WIDTH  tag of the beat on out_data
//  busy       out  1          any stage holds a valid beat
// BEHAVIOUR
//  Reset (async assert, sync release): both stage valids 0; out_valid=0, out_data=0,
//   out_tag=0, busy=0; in_ready=1 in the first cycle after release.
//  Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//   in_valid/in_a/in_b/in_tag need not be held after acceptance; out_* held stable while out_valid & !out_ready.
//  Stage 1 (S1): canonicalise: x_c = (x == p) ? 0 : x for a and b;
//   d = {1'b0,a_c} - {1'b0,b_c} (32 bit); register d[30:0], borrow=d[31], tag, s1_valid.
//  Stage 2 (S2): r = borrow ? (d[30:0] + p) mod 2^31 : d[30:0]; register r, tag, s2_valid.
//   Range: a_c - b_c in (-p, p), so r is in [0, p-1]; no further reduction.
//  Latency: 2 cycles accept->out_valid with no stall; throughput 1 beat/cycle.
//  Ready chaining: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv;
//   in_ready = s1_adv (combinational from out_ready; no input-to-output comb path on data).
//  S2 loads from S1 when s2_adv; s2_valid <= s1_valid on load. S1 loads when s1_adv; s1_valid <= in_valid.
//  Full: both stages valid and out_ready=0 -> in_ready=0; exactly 2 beats buffered, none dropped.
//  Simultaneous consume and accept in a full pipe: both occur in the same cycle, no bubble.
//  Empty: out_valid=0, out_data holds last value (don't-care for checking), busy=0.
//  Ordering: results leave in acceptance order; tags never reordered or duplicated.
//  Reset mid-operation: all in-flight beats discarded, no spurious out_valid afterwards.
//  busy = s1_valid | s2_valid.
// STRUCTURE
//  Shared package m31_pkg: M31_P = 31'h7FFF_FFFF, typedef logic [30:0] m31_t, M31_WIDTH = 31.
//  One sub-module: m31_canonicalize (combinational, x==p -> 0), instanced for a and b;
//   also reusable by adder/reducer paths. Stage registers and handshake stay in this module.
// TESTING
//  1. a=5, b=3, tag=1 -> 2 cycles later out_data=2, out_tag=1, one beat only.
//  2. a=3, b=5 -> out_data=2147483645 (p-2); a=0, b=1 -> 2147483646 (p-1).
//  3. Non-canonical: a=p, b=0 -> 0; a=0, b=p -> 0; a=p, b=p -> 0; a=p-1, b=p -> p-1.
//  4. Backpressure: out_ready=0, stream 3 beats (tags 1..3) -> in_ready drops after 2
//     accepted; raise out_ready -> results tags 1,2,3 in order, no loss/duplication.
//  5. Full throughput: 100 random canonical/non-canonical beats, out_ready=1 -> one result
//     per cycle after 2-cycle latency, all match scoreboard ((a-b) mod p), busy falls after last.
//  6. Reset with 2 beats in flight -> out_valid=0, busy=0 immediately; no stale beat after release.

Source files
------------

// File: rtl/m31_pkg.sv
// Shared M31 field definitions (p = 2^31 - 1) for the Monolith datapath.
//   M31_WIDTH : bit width of a field element
//   M31_P     : field modulus
//   m31_t     : field element type
package m31_pkg;

  localparam int unsigned M31_WIDTH = 31;

  typedef logic [M31_WIDTH-1:0] m31_t;

  localparam m31_t M31_P = 31'h7FFF_FFFF;

endpackage

// File: rtl/m31_canonicalize.sv
// Maps an M31 value in [0, p] to canonical form in [0, p-1].
// p is congruent to 0, so it is the only value that needs rewriting.
//   i_x : input value, range [0, p]
//   o_x : canonical value, range [0, p-1]
module m31_canonicalize
  import m31_pkg::*;
(
  input  m31_t i_x,
  output m31_t o_x
);

  assign o_x = (i_x == M31_P) ? '0 : i_x;

endmodule

// File: rtl/m31_subtractor_pipe.sv
// Two-stage pipelined M31 modular subtractor: out_data = (in_a - in_b) mod p, canonical.
// Valid/ready handshake on both sides; an opaque tag travels with each beat.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_a, in_b, in_tag   : minuend, subtrahend (each in [0, p]), tag
//   out_valid/out_ready  : output handshake
//   out_data, out_tag    : result in [0, p-1], tag of that beat
//   busy                 : any stage holds a valid beat
module m31_subtractor_pipe
  import m31_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  m31_t                 in_a,
  input  m31_t                 in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output m31_t                 out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  m31_t                 w_a_c;
  m31_t                 w_b_c;
  logic [M31_WIDTH:0]   w_diff;
  m31_t                 w_r;
  logic                 w_s1_adv;
  logic                 w_s2_adv;

  logic                 r_s1_valid;
  m31_t                 r_s1_diff;
  logic                 r_s1_borrow;
  logic [TAG_WIDTH-1:0] r_s1_tag;

  logic                 r_s2_valid;
  m31_t                 r_s2_data;
  logic [TAG_WIDTH-1:0] r_s2_tag;

  m31_canonicalize u_canon_a (
    .i_x (in_a),
    .o_x (w_a_c)
  );

  m31_canonicalize u_canon_b (
    .i_x (in_b),
    .o_x (w_b_c)
  );

  // Each stage may advance when empty or when the stage after it advances.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Extra MSB of the difference is the borrow (set when a_c < b_c).
  assign w_diff = {1'b0, w_a_c} - {1'b0, w_b_c};

  // a_c - b_c lies in (-p, p): a single +p (mod 2^31) on borrow lands in [0, p-1].
  assign w_r = r_s1_borrow ? (r_s1_diff + M31_P) : r_s1_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_diff   <= '0;
      r_s1_borrow <= 1'b0;
      r_s1_tag    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_diff   <= w_diff[M31_WIDTH-1:0];
        r_s1_borrow <= w_diff[M31_WIDTH];
        r_s1_tag    <= in_tag;
      end
    end
  end

  // Data registers only load on a valid beat so out_data keeps its last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_r;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_tag   = r_s2_tag;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_m31_subtractor_pipe.sv
module tb_m31_subtractor_pipe;

  localparam logic [30:0] P = 31'h7FFF_FFFF;

  typedef struct packed {
    logic [3:0]  tag;
    logic [30:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_a;
  logic [30:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  int n_checks;
  int n_fail;
  int n_in;
  int n_out;
  int n_stall;
  beat_t sb[$];

  m31_subtractor_pipe #(
    .TAG_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [30:0] model(input logic [30:0] a, input logic [30:0] b);
    longint ac;
    longint bc;
    ac = (a == P) ? 0 : longint'(a);
    bc = (b == P) ? 0 : longint'(b);
    return 31'((ac - bc + longint'(P)) % longint'(P));
  endfunction

  // Output monitor: the handshake seen at negedge is the one the next posedge commits.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_data", 64'(out_data), 64'(e.data));
      end
      n_out++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [30:0] a, input logic [30:0] b, input logic [3:0] tag,
                      input logic [30:0] exp);
    bit accepted;
    accepted = 0;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{tag: tag, data: exp});
        n_in++;
        accepted = 1;
      end else begin
        n_stall++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (n_out == n_in && !out_valid) break;
    end
    check("drain_count", 64'(n_out), 64'(n_in));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_in      = 0;
    n_out     = 0;
    n_stall   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // 1. Basic beat, latency and single result
    send(31'd5, 31'd3, 4'd1, 31'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("single_beat", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // 2/3. Borrow cases and non-canonical operands
    send(31'd3, 31'd5, 4'd2, 31'd2147483645);
    send(31'd0, 31'd1, 4'd3, 31'd2147483646);
    send(P, 31'd0, 4'd4, 31'd0);
    send(31'd0, P, 4'd5, 31'd0);
    send(P, P, 4'd6, 31'd0);
    send(P - 31'd1, P, 4'd7, P - 31'd1);
    in_valid = 1'b0;
    drain();

    // 4. Backpressure: two beats fill the pipe, third waits until out_ready rises
    out_ready = 1'b0;
    send(31'd100, 31'd1, 4'd1, 31'd99);
    send(31'd200, 31'd1, 4'd2, 31'd199);
    fork
      send(31'd300, 31'd1, 4'd3, 31'd299);
      begin
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_tag", 64'(out_tag), 64'd1);
        check("hold_data", 64'(out_data), 64'd99);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    // 5. Full throughput with random operands
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      logic [30:0] a;
      logic [30:0] b;
      a = ($urandom_range(0, 7) == 0) ? P : 31'($urandom_range(0, 32'h7FFF_FFFF));
      b = ($urandom_range(0, 7) == 0) ? P : 31'($urandom_range(0, 32'h7FFF_FFFF));
      send(a, b, 4'(i), model(a, b));
    end
    in_valid = 1'b0;
    check("stream_stalls", 64'(n_stall), 64'd0);
    drain();
    @(negedge clk);
    check("stream_busy_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // 6. Reset with two beats in flight
    out_ready = 1'b0;
    send(31'd7, 31'd2, 4'd8, 31'd5);
    send(31'd9, 31'd2, 4'd9, 31'd7);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    sb.delete();
    n_out = n_in;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("no_stale_beat", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check("postrst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
